// File: rtl/acq_framer.sv
// Acquisition framer: arms on ctl_start, starts a frame on a qualified trigger,
// decimates the input stream and emits one fixed-length AXI4-stream frame.
// The frame ends with TLAST so the downstream buffer restarts at address 0.
//
// state | meaning
// IDLE  | waiting for ctl_start; trigger ignored
// ARMED | config latched, waiting for trg on a valid input beat
// ACQ   | frame in progress, decimating and counting emitted samples
module acq_framer #(
  parameter int DW  = 16,
  parameter int LW  = 14,
  parameter int DCW = 17
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           ctl_start,
  input  logic           ctl_stop,
  input  logic [LW-1:0]  cfg_len,
  input  logic [DCW-1:0] cfg_dec,
  input  logic           trg,
  input  logic [DW-1:0]  sti_tdata,
  input  logic           sti_tvalid,
  output logic           sti_tready,
  output logic [DW-1:0]  sto_tdata,
  output logic           sto_tvalid,
  input  logic           sto_tready,
  output logic           sto_tlast,
  output logic           sts_run,
  output logic           sts_trg,
  output logic           sts_done,
  output logic           sts_ovf
);

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_ACQ} state_t;

  state_t         state, state_nxt;
  logic [LW-1:0]  len_r, smp_cnt;
  logic [DCW-1:0] dec_r, dec_cnt;
  logic           arm, take, emit, last, load, drop;

  // The input is never back-pressured; frame timing follows the input stream.
  assign sti_tready = 1'b1;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next state plus per-beat strobes. Stop always wins over start/trigger.
  // The trigger beat is processed exactly like an ACQ beat at phase 0.
  always_comb begin
    state_nxt = state;
    arm       = 1'b0;
    take      = 1'b0;
    emit      = 1'b0;
    last      = 1'b0;
    case (state)
      S_IDLE: begin
        if (ctl_start && !ctl_stop) begin
          state_nxt = S_ARMED;
          arm       = 1'b1;
        end
      end
      S_ARMED: begin
        if (ctl_stop) begin
          state_nxt = S_IDLE;
        end else if (trg && sti_tvalid) begin
          state_nxt = S_ACQ;
          take      = 1'b1;
        end
      end
      S_ACQ: begin
        if (ctl_stop) state_nxt = S_IDLE;
        else          take = sti_tvalid;
      end
      default: state_nxt = S_IDLE;
    endcase
    emit = take && (dec_cnt == '0);
    last = emit && (smp_cnt == len_r);
    if (last) state_nxt = S_IDLE;
  end

  // A sample that finds the output register occupied and stalled is dropped.
  assign load = emit && (!sto_tvalid || sto_tready);
  assign drop = emit && !load;

  // Config latch and decimation / frame-length counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_r   <= '0;
      dec_r   <= '0;
      dec_cnt <= '0;
      smp_cnt <= '0;
    end else if (arm) begin
      len_r   <= cfg_len;
      dec_r   <= cfg_dec;
      dec_cnt <= '0;
      smp_cnt <= '0;
    end else if (take) begin
      dec_cnt <= (dec_cnt == dec_r) ? '0 : dec_cnt + DCW'(1);
      if (emit) smp_cnt <= smp_cnt + LW'(1);
    end
  end

  // One-deep output register; a dropped final sample moves TLAST onto the
  // held beat so every frame is still terminated.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sto_tdata  <= '0;
      sto_tvalid <= 1'b0;
      sto_tlast  <= 1'b0;
    end else if (load) begin
      sto_tdata  <= sti_tdata;
      sto_tvalid <= 1'b1;
      sto_tlast  <= last;
    end else if (drop) begin
      if (last) sto_tlast <= 1'b1;
    end else if (sto_tvalid && sto_tready) begin
      sto_tvalid <= 1'b0;
      sto_tlast  <= 1'b0;
    end
  end

  // Sticky overflow, cleared only when a new acquisition is armed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       sts_ovf <= 1'b0;
    else if (arm)  sts_ovf <= 1'b0;
    else if (drop) sts_ovf <= 1'b1;
  end

  assign sts_run  = (state != S_IDLE);
  assign sts_trg  = (state == S_ACQ);
  assign sts_done = sto_tvalid && sto_tready && sto_tlast;

endmodule

// File: tb/tb_acq_framer.sv
// Directed bench for acq_framer with a scoreboard of expected output beats.
module tb_acq_framer;

  localparam int DW  = 16;
  localparam int LW  = 14;
  localparam int DCW = 17;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           ctl_start = 1'b0, ctl_stop = 1'b0;
  logic [LW-1:0]  cfg_len = '0;
  logic [DCW-1:0] cfg_dec = '0;
  logic           trg = 1'b0;
  logic [DW-1:0]  sti_tdata = '0;
  logic           sti_tvalid = 1'b0;
  logic           sti_tready;
  logic [DW-1:0]  sto_tdata;
  logic           sto_tvalid;
  logic           sto_tready = 1'b1;
  logic           sto_tlast;
  logic           sts_run, sts_trg, sts_done, sts_ovf;

  int n_assert = 0;
  int n_fail   = 0;
  int ramp     = 0;
  logic [DW:0] sb[$];   // {tlast, tdata}

  acq_framer #(.DW(DW), .LW(LW), .DCW(DCW)) dut (
    .clk(clk), .rst(rst),
    .ctl_start(ctl_start), .ctl_stop(ctl_stop),
    .cfg_len(cfg_len), .cfg_dec(cfg_dec), .trg(trg),
    .sti_tdata(sti_tdata), .sti_tvalid(sti_tvalid), .sti_tready(sti_tready),
    .sto_tdata(sto_tdata), .sto_tvalid(sto_tvalid), .sto_tready(sto_tready),
    .sto_tlast(sto_tlast),
    .sts_run(sts_run), .sts_trg(sts_trg), .sts_done(sts_done), .sts_ovf(sts_ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock with the given inputs; returns at posedge+1 with pulses cleared.
  task automatic drive(input bit v, input bit t, input bit st, input bit sp);
    sti_tvalid = v;
    sti_tdata  = DW'(ramp);
    trg        = t;
    ctl_start  = st;
    ctl_stop   = sp;
    @(posedge clk);
    #1;
    trg       = 1'b0;
    ctl_start = 1'b0;
    ctl_stop  = 1'b0;
    if (v) ramp++;
  endtask

  task automatic push(input int d, input bit l);
    sb.push_back({l, DW'(d)});
  endtask

  // Output monitor: every accepted beat must match the head of the scoreboard.
  always @(negedge clk) begin
    logic [DW:0] e;
    if (!rst && sto_tvalid && sto_tready) begin
      chk("sb_has_entry", (sb.size() != 0), 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("beat_data", sto_tdata, e[DW-1:0]);
        chk("beat_last", sto_tlast, e[DW]);
        chk("done_on_last", sts_done, e[DW]);
      end
    end else begin
      chk("done_quiet", sts_done, 0);
    end
  end

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tvalid", sto_tvalid, 0);
    chk("rst_tdata",  sto_tdata, 0);
    chk("rst_tlast",  sto_tlast, 0);
    chk("rst_run",    sts_run, 0);
    chk("rst_trg",    sts_trg, 0);
    chk("rst_ovf",    sts_ovf, 0);
    chk("sti_tready", sti_tready, 1);
    rst = 1'b0;
    drive(0, 0, 0, 0);

    // 1: len 8, no decimation, trigger at 100
    cfg_len = 7; cfg_dec = 0; ramp = 0;
    for (int i = 100; i <= 107; i++) push(i, i == 107);
    drive(1, 0, 1, 0);
    chk("t1_armed", sts_run, 1);
    while (ramp <= 112) drive(1, ramp == 100, 0, 0);
    chk("t1_run_low", sts_run, 0);
    chk("t1_sb_empty", sb.size(), 0);

    // 2: len 4, decimate by 3, trigger at 50
    cfg_len = 3; cfg_dec = 2; ramp = 0;
    push(50, 0); push(53, 0); push(56, 0); push(59, 1);
    drive(1, 0, 1, 0);
    while (ramp <= 62) begin
      int s;
      s = ramp;
      drive(1, ramp == 50, 0, 0);
      if (s >= 45) chk("t2_sts_trg", sts_trg, (s >= 50 && s < 59));
    end
    chk("t2_sb_empty", sb.size(), 0);

    // 3: stall the output; held beat 50 picks up TLAST, overflow latched
    cfg_len = 3; cfg_dec = 0; ramp = 0;
    push(50, 1);
    drive(1, 0, 1, 0);
    chk("t3_ovf_clear_at_arm", sts_ovf, 0);
    while (ramp <= 56) begin
      int s;
      s = ramp;
      if (s == 50) sto_tready = 1'b0;
      drive(1, s == 50, 0, 0);
      if (s >= 51 && s <= 53) begin
        chk("t3_hold_data", sto_tdata, 50);
        chk("t3_hold_valid", sto_tvalid, 1);
        chk("t3_hold_last", sto_tlast, (s == 53));
      end
      if (s == 53) begin
        chk("t3_ovf_set", sts_ovf, 1);
        sto_tready = 1'b1;
      end
    end
    chk("t3_sb_empty", sb.size(), 0);
    drive(1, 0, 1, 0);
    chk("t3_ovf_cleared", sts_ovf, 0);
    drive(1, 0, 0, 1);
    chk("t3_stopped", sts_run, 0);

    // 4: abort mid-frame, then trigger and start+stop in IDLE
    cfg_len = 15; cfg_dec = 0; ramp = 0;
    push(10, 0); push(11, 0);
    drive(1, 0, 1, 0);
    while (ramp <= 11) drive(1, ramp == 10, 0, 0);
    drive(1, 0, 0, 1);
    chk("t4_run_after_stop", sts_run, 0);
    for (int i = 0; i < 6; i++) begin
      drive(1, 1, 0, 0);
      chk("t4_no_output", sto_tvalid, 0);
    end
    drive(1, 0, 1, 1);
    chk("t4_start_stop", sts_run, 0);
    chk("t4_sb_empty", sb.size(), 0);

    // 5: ignored triggers, then single-sample frame
    ramp = 0;
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 0, 0);
      chk("t5_idle_trg", sto_tvalid, 0);
    end
    cfg_len = 0;
    drive(1, 0, 1, 0);
    cfg_len = 9;   // must not affect the armed frame
    drive(0, 1, 0, 0);
    chk("t5_still_armed", sts_run, 1);
    chk("t5_not_acq", sts_trg, 0);
    drive(0, 0, 0, 0);
    chk("t5_no_beat", sto_tvalid, 0);
    push(ramp, 1);
    drive(1, 1, 0, 0);
    chk("t5_single_done", sts_run, 0);
    drive(1, 0, 0, 0);
    drive(1, 0, 0, 0);
    chk("t5_sb_empty", sb.size(), 0);

    // 6: async reset with a pending beat, then a clean frame
    cfg_len = 7; cfg_dec = 0; ramp = 0;
    push(5, 0);
    drive(1, 0, 1, 0);
    while (ramp <= 6) drive(1, ramp == 5, 0, 0);
    sto_tready = 1'b0;
    drive(1, 0, 0, 0);
    chk("t6_pending", sto_tvalid, 1);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_tvalid", sto_tvalid, 0);
    chk("t6_rst_tdata",  sto_tdata, 0);
    chk("t6_rst_tlast",  sto_tlast, 0);
    chk("t6_rst_run",    sts_run, 0);
    chk("t6_rst_trg",    sts_trg, 0);
    chk("t6_rst_ovf",    sts_ovf, 0);
    chk("t6_rst_done",   sts_done, 0);
    sto_tready = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    cfg_len = 7; cfg_dec = 1; ramp = 0;
    for (int i = 0; i < 8; i++) push(20 + 2 * i, i == 7);
    drive(1, 0, 1, 0);
    while (ramp <= 38) drive(1, ramp == 20, 0, 0);
    chk("t6_run_low", sts_run, 0);
    chk("t6_sb_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
